// File: rtl/data_mem_io.sv
// data_mem_io: word RAM plus LED/switch IO port; debouncer built when DATA_MEM_IO_DEBOUNCE_EN is defined
module data_mem_io #(
    parameter int RAM_AW    = 10,
    parameter int DB_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [11:0] sw_i,
    output logic [31:0] data_o,
    output logic [11:0] led_o,
    output logic [11:0] sw_o
);
    logic [31:0]       ram [2**RAM_AW];
    logic [RAM_AW-1:0] idx;
    logic              is_io;
    logic [11:0]       led_q;
    logic [11:0]       s1_q, s2_q;
    logic              unused_addr;

    assign idx         = addr_i[RAM_AW+1:2];
    assign is_io       = addr_i[31];
    assign unused_addr = ^{addr_i[30:RAM_AW+2], addr_i[1:0]};
    assign led_o       = led_q;

    // Combinational load path: RAM word, switch value, or zero when idle
    always_comb data_o = !ce_i ? 32'd0 : is_io ? {20'd0, sw_o} : ram[idx];

    // RAM store; held off while reset is asserted, contents never cleared
    always_ff @(posedge clk) begin
        if (rst && ce_i && we_i && !is_io) ram[idx] <= data_i;
    end

    // LED register loaded by IO stores
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) led_q <= '0;
        else if (ce_i && we_i && is_io) led_q <= data_i[11:0];
    end

    // Two-flop synchronizer for the asynchronous switch pins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) {s1_q, s2_q} <= '0;
        else {s1_q, s2_q} <= {sw_i, s1_q};
    end

`ifdef DATA_MEM_IO_DEBOUNCE_EN
    typedef enum logic {IDLE, COUNT} state_e;
    state_e      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [11:0] s3_q, sw_q, sw_d;

    assign sw_o = sw_q;

    // Debouncer state, counter, history flop and accepted switch value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s3_q    <= '0;
            sw_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s3_q    <= s2_q;
            sw_q    <= sw_d;
        end
    end

    // Accept a new value only after it has been stable for DB_CYCLES cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sw_d    = sw_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (s2_q != sw_q) state_d = COUNT;
        end else if (s2_q == sw_q) begin
            cnt_d   = '0;
            state_d = IDLE;
        end else if (s2_q != s3_q) begin
            cnt_d = '0;
        end else if (cnt_q == 20'(DB_CYCLES - 1)) begin
            sw_d    = s2_q;
            cnt_d   = '0;
            state_d = IDLE;
        end else begin
            cnt_d = cnt_q + 20'd1;
        end
    end
`else
    logic [19:0] unused_db;

    assign unused_db = 20'(DB_CYCLES);
    assign sw_o      = s2_q;
`endif
endmodule

// File: tb/tb_data_mem_io.sv
// tb_data_mem_io: directed self-checking bench for data_mem_io
module tb_data_mem_io;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce_i = 1'b0, we_i = 1'b0;
    logic [31:0] addr_i = '0, data_i = '0, data_o;
    logic [11:0] sw_i = '0, led_o, sw_o;
    int          checks = 0, failures = 0;
    int          lat;
    logic [11:0] seen;

`ifdef DATA_MEM_IO_DEBOUNCE_EN
    localparam int LAT_MIN = 5, LAT_MAX = 7;
`else
    localparam int LAT_MIN = 2, LAT_MAX = 2;
`endif

    data_mem_io #(.RAM_AW(10), .DB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .sw_i(sw_i), .data_o(data_o), .led_o(led_o), .sw_o(sw_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ce_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
        @(posedge clk); #1;
        ce_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        ce_i = 1'b1; we_i = 1'b0; addr_i = a;
        #1 check(tag, data_o, exp);
        ce_i = 1'b0;
    endtask

    task automatic wait_sw(input logic [11:0] exp);
        lat = 0;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (sw_o == exp) lat = i;
        end
    endtask

    initial begin
        #23;
        check("rst_led", 32'(led_o), 32'h0);
        check("rst_sw", 32'(sw_o), 32'h0);
        check("rst_data_idle", data_o, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        wr(32'h0000_0010, 32'h1234_5678);
        wr(32'h0000_0000, 32'hCAFE_0000);
        rd("ram_rd", 32'h0000_0010, 32'h1234_5678);
        rd("ram_alias", 32'h0000_1010, 32'h1234_5678);
        rd("ram_unaligned", 32'h0000_0013, 32'h1234_5678);
        wr(32'h8000_0000, 32'hFFFF_FABC);
        check("io_led", 32'(led_o), 32'h0000_0ABC);
        rd("io_ram_kept", 32'h0000_0000, 32'hCAFE_0000);
        wr(32'h0000_0030, 32'h0000_0123);
        check("ram_wr_led_kept", 32'(led_o), 32'h0000_0ABC);
        ce_i = 1'b0; we_i = 1'b1; addr_i = 32'h0000_0030; data_i = 32'hDEAD_BEEF;
        #1 check("ce0_data", data_o, 32'h0);
        @(posedge clk); #1;
        we_i = 1'b0;
        rd("ce0_no_write", 32'h0000_0030, 32'h0000_0123);
        ce_i = 1'b0; we_i = 1'b1; addr_i = 32'h8000_0000; data_i = 32'h0000_0111;
        @(posedge clk); #1;
        we_i = 1'b0;
        check("ce0_no_led", 32'(led_o), 32'h0000_0ABC);
        wr(32'h0000_0020, 32'hAAAA_AAAA);
        ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0020; data_i = 32'h5555_5555;
        #1 check("rw_before", data_o, 32'hAAAA_AAAA);
        @(posedge clk); #1;
        we_i = 1'b0;
        check("rw_after", data_o, 32'h5555_5555);
        ce_i = 1'b0;
        rd("io_rd_sw0", 32'h8000_0004, 32'h0);
        sw_i = 12'h5A5;
        wait_sw(12'h5A5);
        check("sw_lat_min", 32'(lat >= LAT_MIN), 32'h1);
        check("sw_lat_max", 32'(lat <= LAT_MAX), 32'h1);
        rd("io_rd_sw", 32'h8000_0004, 32'h0000_05A5);
        sw_i = 12'h000;
        wait_sw(12'h000);
        check("sw_back0", 32'(sw_o), 32'h0);
        sw_i = 12'h001;
        seen = '0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (i == 1) sw_i = 12'h000;
            seen |= sw_o;
        end
`ifdef DATA_MEM_IO_DEBOUNCE_EN
        check("glitch_reject", 32'(seen), 32'h0);
`else
        check("glitch_pass", 32'(seen), 32'h001);
`endif
        wr(32'h8000_0000, 32'h0000_0FFF);
        check("led_fff", 32'(led_o), 32'h0000_0FFF);
        sw_i = 12'h5A5;
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        #2;
        check("mid_rst_led", 32'(led_o), 32'h0);
        check("mid_rst_sw", 32'(sw_o), 32'h0);
        @(negedge clk) rst = 1'b1;
        wait_sw(12'h5A5);
        check("post_rst_lat_min", 32'(lat >= LAT_MIN), 32'h1);
        check("post_rst_lat_max", 32'(lat <= LAT_MAX + 1), 32'h1);
        rd("post_rst_ram", 32'h0000_0010, 32'h1234_5678);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
